// File: rtl/mul_acc_unit.sv
// mul_acc_unit: accumulate half of the my_mul multiply-accumulate path.
// Sums a batch of unsigned products into a saturating accumulator and hands
// the batch result to a consumer over a valid/ready handshake. Only one batch
// is ever in flight: the input side is closed while a result is waiting.
module mul_acc_unit #(
    parameter int BITWIDTH = 32,
    parameter int COUNT_W  = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] prod,
    input  logic                prod_ovf,
    input  logic [COUNT_W-1:0]  len,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] acc_out,
    output logic                acc_sat
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]          state;
    logic [BITWIDTH-1:0] acc;
    logic                sat;
    logic [COUNT_W-1:0]  remaining;

    logic                accept;
    logic                take;
    logic [COUNT_W-1:0]  first_remaining;
    logic [BITWIDTH:0]   sum;
    logic                sum_sat;

    // Handshake qualifiers; the input side is held closed during reset and
    // while a finished batch waits for the consumer.
    always_comb begin
        in_ready  = (state != DONE) && !reset;
        out_valid = (state == DONE);
        accept    = in_valid && in_ready;
        take      = out_valid && out_ready;
    end

    // Beats still owed after the first one; a zero length counts as one beat.
    always_comb begin
        if (len == '0) begin
            first_remaining = '0;
        end else begin
            first_remaining = len - COUNT_W'(1);
        end
    end

    // Widened add exposes the carry; saturation is sticky for the whole batch.
    always_comb begin
        sum     = {1'b0, acc} + {1'b0, prod};
        sum_sat = sum[BITWIDTH] || prod_ovf || sat;
    end

    // Batch sequencing and accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            acc       <= '0;
            sat       <= 1'b0;
            remaining <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc       <= prod_ovf ? '1 : prod;
                        sat       <= prod_ovf;
                        remaining <= first_remaining;
                        state     <= (first_remaining == '0) ? DONE : ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        if (sum_sat) begin
                            acc <= '1;
                            sat <= 1'b1;
                        end else begin
                            acc <= sum[BITWIDTH-1:0];
                        end
                        remaining <= remaining - COUNT_W'(1);
                        if (remaining == COUNT_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (take) begin
                        state <= IDLE;
                        acc   <= '0;
                        sat   <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // The accumulator registers are the result; they are frozen while in DONE.
    always_comb begin
        acc_out = acc;
        acc_sat = sat;
    end

endmodule

// File: tb/tb_mul_acc_unit.sv
// tb_mul_acc_unit: directed bench for mul_acc_unit with a batch-level
// reference model and literal expectations for each directed scenario.
module tb_mul_acc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] prod;
    logic        prod_ovf;
    logic [3:0]  len;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] acc_out;
    logic        acc_sat;

    int assertions = 0;
    int failures   = 0;

    // Reference model state: the batch being collected and the pending result.
    logic            mBusy    = 1'b0;
    logic            mPending = 1'b0;
    int              mCount   = 0;
    int              mNeed    = 0;
    longint unsigned mSum     = 0;
    logic            mSat     = 1'b0;
    logic [31:0]     mResult  = '0;
    logic            mResSat  = 1'b0;

    mul_acc_unit #(.BITWIDTH(32), .COUNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .prod      (prod),
        .prod_ovf  (prod_ovf),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_out   (acc_out),
        .acc_sat   (acc_sat)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        assertions++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Batch model: collects plain integer sums per batch, saturating when the
    // true sum leaves 32 bits or any product arrives flagged as overflowed.
    always @(posedge clk) begin : modelProc
        longint unsigned s;
        int              cnt;
        int              need;
        logic            st;
        if (reset) begin
            mBusy    <= 1'b0;
            mPending <= 1'b0;
            mCount   <= 0;
            mSum     <= 0;
            mSat     <= 1'b0;
        end else if (mPending) begin
            if (out_ready) mPending <= 1'b0;
        end else if (in_valid) begin
            s    = mBusy ? mSum : 0;
            cnt  = mBusy ? mCount : 0;
            st   = mBusy ? mSat : 1'b0;
            need = mBusy ? mNeed : ((len == 4'd0) ? 1 : int'(len));
            s    = s + longint'(prod);
            cnt  = cnt + 1;
            if (prod_ovf || s > 64'h0000_0000_FFFF_FFFF) st = 1'b1;
            if (cnt == need) begin
                mPending <= 1'b1;
                mBusy    <= 1'b0;
                mResult  <= st ? 32'hFFFF_FFFF : s[31:0];
                mResSat  <= st;
            end else begin
                mBusy  <= 1'b1;
                mSum   <= s;
                mCount <= cnt;
                mSat   <= st;
                mNeed  <= need;
            end
        end
    end

    // Every cycle, compare handshake outputs and any presented result with the model.
    always @(negedge clk) begin
        checkOutput("in_ready", 64'(in_ready), 64'(!mPending && !reset));
        checkOutput("out_valid", 64'(out_valid), 64'(mPending));
        if (mPending) begin
            checkOutput("model_acc_out", 64'(acc_out), 64'(mResult));
            checkOutput("model_acc_sat", 64'(acc_sat), 64'(mResSat));
        end
    end

    // Present one beat and hold it until the unit accepts it.
    task automatic applyStimulus(input logic [31:0] p, input logic ovf,
                                 input logic [3:0] l);
        bit done;
        done     = 1'b0;
        in_valid = 1'b1;
        prod     = p;
        prod_ovf = ovf;
        len      = l;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            done = in_ready;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            assertions++;
            failures++;
            $display("[TB] FAIL accept_timeout: got no accept, expected accept within 20 cycles");
        end
    endtask

    task automatic idleInputs();
        in_valid = 1'b0;
        prod     = '0;
        prod_ovf = 1'b0;
        len      = '0;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Wait for a result and pin it against a hand-computed value.
    task automatic expectResult(input string name, input logic [31:0] val,
                                input logic sat);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                checkOutput({name, "_acc_out"}, 64'(acc_out), 64'(val));
                checkOutput({name, "_acc_sat"}, 64'(acc_sat), 64'(sat));
            end
        end
        if (!seen) begin
            assertions++;
            failures++;
            $display("[TB] FAIL %s_timeout: got out_valid=0, expected result within 20 cycles", name);
        end
        nextCycle();
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        idleInputs();
        in_valid  = 1'b1;
        prod      = 32'd99;
        len       = 4'd1;
        nextCycle();
        nextCycle();
        @(negedge clk);
        checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
        checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
        checkOutput("reset_acc_out", 64'(acc_out), 64'd0);
        checkOutput("reset_acc_sat", 64'(acc_sat), 64'd0);
        nextCycle();
        idleInputs();
        reset = 1'b0;
        nextCycle();

        // Three back-to-back beats; result visible right after the last accept.
        applyStimulus(32'd5, 1'b0, 4'd3);
        applyStimulus(32'd7, 1'b0, 4'd3);
        applyStimulus(32'd9, 1'b0, 4'd3);
        idleInputs();
        @(negedge clk);
        checkOutput("s1_out_valid", 64'(out_valid), 64'd1);
        checkOutput("s1_acc_out", 64'(acc_out), 64'h15);
        checkOutput("s1_acc_sat", 64'(acc_sat), 64'd0);
        nextCycle();
        @(negedge clk);
        checkOutput("s1_out_valid_after_take", 64'(out_valid), 64'd0);
        nextCycle();

        // Carry out of the accumulator saturates.
        applyStimulus(32'hFFFF_FFF0, 1'b0, 4'd2);
        applyStimulus(32'h20, 1'b0, 4'd2);
        idleInputs();
        expectResult("s2", 32'hFFFF_FFFF, 1'b1);

        // Overflow flag on the first beat saturates the whole batch.
        applyStimulus(32'h10, 1'b1, 4'd2);
        applyStimulus(32'h1, 1'b0, 4'd2);
        idleInputs();
        expectResult("s3", 32'hFFFF_FFFF, 1'b1);

        // Zero length behaves as a single beat.
        applyStimulus(32'h1234, 1'b0, 4'd0);
        idleInputs();
        expectResult("s4", 32'h1234, 1'b0);

        // All-ones product without a flag is not saturation.
        applyStimulus(32'hFFFF_FFFF, 1'b0, 4'd1);
        idleInputs();
        expectResult("s4b", 32'hFFFF_FFFF, 1'b0);

        // Bubbles mid-batch, then consumer back-pressure with a beat waiting.
        out_ready = 1'b0;
        applyStimulus(32'd3, 1'b0, 4'd2);
        idleInputs();
        nextCycle();
        nextCycle();
        applyStimulus(32'd4, 1'b0, 4'd2);
        in_valid = 1'b1;
        prod     = 32'd2;
        len      = 4'd1;
        expectResult("s5", 32'd7, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("s5_hold_in_ready", 64'(in_ready), 64'd0);
            checkOutput("s5_hold_acc_out", 64'(acc_out), 64'd7);
            nextCycle();
        end
        out_ready = 1'b1;
        applyStimulus(32'd2, 1'b0, 4'd1);
        idleInputs();
        expectResult("s5_next", 32'd2, 1'b0);

        // Reset mid-batch discards the partial sum.
        applyStimulus(32'd1, 1'b0, 4'd4);
        applyStimulus(32'd1, 1'b0, 4'd4);
        idleInputs();
        reset = 1'b1;
        nextCycle();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("s6_out_valid", 64'(out_valid), 64'd0);
            nextCycle();
        end
        applyStimulus(32'd3, 1'b0, 4'd1);
        idleInputs();
        expectResult("s6", 32'd3, 1'b0);

        nextCycle();
        nextCycle();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 assertions, failures);
        $finish;
    end

endmodule
